serdiv: RTL and testbench
=========================

SERDIV -- requirements
Module: serdiv

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled on rising edge of clk.
REQ-005 a  input  WIDTH  dividend; captured when start is accepted.
REQ-006 b  input  WIDTH  divisor; captured when start is accepted.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse; q, r and dbz are valid from this cycle onward.
REQ-009 q  output  WIDTH  quotient.
REQ-010 r  output  WIDTH  remainder.
REQ-011 dbz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-012 Block SHALL implement a restoring shift/subtract divider, one quotient bit per clock.
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
  - IDLE or DONE + start=1 -> CALC, or DONE if b==0.
  - CALC with step counter = WIDTH-1 -> DONE.
  - DONE + start=0 -> IDLE.
REQ-014 Start SHALL be accepted only in IDLE or DONE; on acceptance, a and b SHALL be captured and the step counter cleared.
REQ-015 start while busy=1 SHALL be ignored, with no effect on operands, counter or outputs.
REQ-016 busy SHALL be high exactly in CALC.
REQ-017 Latency: start accepted at edge k (b!=0) -> q, r and done SHALL update at edge k+WIDTH, giving exactly WIDTH CALC cycles.
REQ-018 done SHALL be high exactly one cycle (state DONE), then return low.
REQ-019 Back-to-back operation: start in DONE SHALL be accepted, so a new operation can begin without passing through IDLE.
REQ-020 Each CALC step SHALL form a WIDTH+1-bit partial remainder, shift in the next dividend bit MSB-first and subtract the divisor.
  - Non-negative result: keep the difference and set quotient bit 1.
  - Otherwise: restore and set quotient bit 0.
REQ-021 Unsigned results SHALL satisfy a == q*b + r with r < b.
REQ-022 b==0 SHALL give the following, with no CALC cycles:
  - next edge: state DONE, done=1, dbz=1;
  - q = all ones;
  - r = captured a.
REQ-023 dbz SHALL be 0 for every completed operation with b!=0.
REQ-024 q, r and dbz SHALL hold their values until the next done pulse.
REQ-025 Intermediate values SHALL NOT be visible on q or r during CALC.

Reset
REQ-026 rst_n=0 SHALL immediately set state IDLE and clear q, r, busy, done, dbz and the counter, without waiting for clk.
REQ-027 Reset during CALC SHALL abort the operation; no done SHALL follow after release.
REQ-028 The first start after reset release SHALL be accepted normally.

Configuration
REQ-029 Macro SERDIV_SIGNED_EN defined: a, b, q and r SHALL be two's complement. The signed path SHALL:
  - take operand magnitudes at capture;
  - run the unsigned core;
  - truncate q toward zero;
  - give r the sign of a;
  - keep latency unchanged.
REQ-030 With SERDIV_SIGNED_EN defined, the following special cases SHALL hold:
  - most-negative / -1 -> q = most-negative value, r=0, dbz=0;
  - b==0 -> q = all ones, r=a, dbz=1.
REQ-031 Macro undefined: purely unsigned operation; no sign logic synthesised.

Verification (WIDTH=8)
REQ-032 Unsigned 100/7: start at edge k -> busy high for 8 cycles; done at edge k+8 with q=0x0E, r=0x02, dbz=0.
REQ-033 Unsigned 0x05/0x00 -> done one cycle after start with q=0xFF, r=0x05, dbz=1, busy never high.
REQ-034 Unsigned 255/1, then start held high in DONE with 255/255 -> first q=0xFF, r=0x00; second q=0x01, r=0x00 exactly 8 cycles later.
REQ-035 Stimulus and required response for abort/ignore:
  - start 200/3; pulse start with 9/2 during CALC -> result still q=0x42, r=0x02;
  - repeat, drive rst_n=0 at CALC cycle 4 -> all outputs 0 at once, no done afterwards.
REQ-036 SERDIV_SIGNED_EN defined:
  - -100/7 -> q=0xF2, r=0xFE;
  - 100/-7 -> q=0xF2, r=0x02;
  - -128/-1 -> q=0x80, r=0x00.

Source files
------------

// File: rtl/serdiv.sv
// serdiv: restoring shift/subtract divider, one quotient bit per clock.
// Optional feature: define SERDIV_SIGNED_EN for two's-complement operands
// (magnitudes are divided, quotient truncates toward zero, remainder takes
// the sign of the dividend). Without the macro the block is purely unsigned.
// Handshake: start is taken on a rising edge only in IDLE or DONE; busy is high
// for the whole calculation, and done pulses for one cycle when q/r/dbz update.
module serdiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic             w_bzero;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_res_q;
  logic [WIDTH-1:0] w_res_r;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_bzero  = (b == '0);

  // One restoring step: shift the next dividend bit (MSB-first) into the
  // partial remainder, subtract the divisor, keep or restore on the sign.
  // The dividend register doubles as the quotient shift register.
  assign w_trial   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_trial - {1'b0, r_div};
  assign w_qbit    = ~w_diff[WIDTH];
  assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};

`ifdef SERDIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  // Magnitudes feed the unsigned core; signs are reapplied on the final step.
  // The most-negative value maps to itself, which the unsigned core reads
  // correctly as 2^(WIDTH-1), so most-negative / -1 returns most-negative.
  assign w_mag_a = a[WIDTH-1] ? (-a) : a;
  assign w_mag_b = b[WIDTH-1] ? (-b) : b;
  assign w_res_q = r_neg_q ? (-w_quo_nxt) : w_quo_nxt;
  assign w_res_r = r_neg_r ? (-w_rem_nxt) : w_rem_nxt;

  // Capture operand signs when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      r_neg_r <= a[WIDTH-1];
    end
  end
`else
  assign w_mag_a = a;
  assign w_mag_b = b;
  assign w_res_q = w_quo_nxt;
  assign w_res_r = w_rem_nxt;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a zero divisor skips CALC entirely.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_bzero ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  if (start) w_next = w_bzero ? S_DONE : S_CALC;
               else       w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    busy      = (r_state == S_CALC);
    done      = (r_state == S_DONE);
    dbg_state = r_state;
  end

  // Datapath: operand capture, iteration, and result registers that only
  // change on the edge entering DONE so q/r never show partial values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= w_mag_a;
      r_div <= w_mag_b;
      if (w_bzero) begin
        r_q   <= '1;
        r_r   <= a;
        r_dbz <= 1'b1;
      end
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + CW'(1);
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      if (w_last) begin
        r_q   <= w_res_q;
        r_r   <= w_res_r;
        r_dbz <= 1'b0;
      end
    end
  end

  assign q   = r_q;
  assign r   = r_r;
  assign dbz = r_dbz;

endmodule

// File: tb/tb_serdiv.sv
// Directed bench for serdiv (WIDTH=8), unsigned or signed build.
module tb_serdiv;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [7:0] r;
  logic       dbz;
  logic [1:0] dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  serdiv #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .r         (r),
    .dbz       (dbz),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected 200/3 result differs between builds (200 reads as -56 signed).
`ifdef SERDIV_SIGNED_EN
  localparam logic [7:0] ABORT_Q = 8'hEE;
  localparam logic [7:0] ABORT_R = 8'hFE;
`else
  localparam logic [7:0] ABORT_Q = 8'h42;
  localparam logic [7:0] ABORT_R = 8'h02;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to its done pulse. elat counts edges
  // after the accepting edge until done is visible (0 for a zero divisor).
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic [7:0] eq, input logic [7:0] er, input logic ed,
                       input int elat);
    int         lat;
    int         bcnt;
    logic [7:0] q0;
    logic [7:0] r0;
    bit         held;
    q0 = q; r0 = r; held = 1'b1; lat = 0; bcnt = 0;
    a = ta; b = tb_v; start = 1'b1;
    step();
    start = 1'b0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (q !== q0 || r !== r0) held = 1'b0;
      step();
      lat++;
    end
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".busy_cycles"}, bcnt, elat);
    chk({tag, ".held_in_calc"}, {31'd0, held}, 32'd1);
    chk({tag, ".q"}, {24'd0, q}, {24'd0, eq});
    chk({tag, ".r"}, {24'd0, r}, {24'd0, er});
    chk({tag, ".dbz"}, {31'd0, dbz}, {31'd0, ed});
    chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    step();
    chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, ".q_hold"}, {24'd0, q}, {24'd0, eq});
  endtask

  initial begin : stim
    int  n;
    bit  saw_done;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    // Reset state.
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.q", {24'd0, q}, 32'd0);
    chk("rst.r", {24'd0, r}, 32'd0);
    chk("rst.dbz", {31'd0, dbz}, 32'd0);
    chk("rst.state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic operations.
    do_op("u100_7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 8);
    do_op("div0", 8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 0);
    do_op("u13_4", 8'd13, 8'd4, 8'h03, 8'h01, 1'b0, 8);
`ifdef SERDIV_SIGNED_EN
    do_op("s-100_7", 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 8);
    do_op("s100_-7", 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 8);
    do_op("s-128_-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 8);
    do_op("s_div0", 8'h85, 8'h00, 8'hFF, 8'h85, 1'b1, 0);
    do_op("s7_-2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 8);
`else
    do_op("u0_5", 8'd0, 8'd5, 8'h00, 8'h00, 1'b0, 8);
    do_op("u7_9", 8'd7, 8'd9, 8'h00, 8'h07, 1'b0, 8);
    do_op("u250_16", 8'd250, 8'd16, 8'h0F, 8'h0A, 1'b0, 8);
    do_op("u128_1", 8'd128, 8'd1, 8'h80, 8'h00, 1'b0, 8);
`endif

    // Back-to-back: start held high through CALC and into DONE.
    a = 8'd255; b = 8'd1; start = 1'b1;
    step();
    a = 8'd255; b = 8'd255;
    n = 0;
    while (!done && n < 40) begin step(); n++; end
    chk("b2b.first_lat", n, 8);
    chk("b2b.first_q", {24'd0, q}, 32'hFF);
    chk("b2b.first_r", {24'd0, r}, 32'h00);
    step();
    start = 1'b0;
    chk("b2b.reenter_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin step(); n++; end
    chk("b2b.second_lat", n, 8);
    chk("b2b.second_q", {24'd0, q}, 32'h01);
    chk("b2b.second_r", {24'd0, r}, 32'h00);
    step();

    // Start pulse with new operands during CALC is ignored.
    a = 8'd200; b = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 8'd9; b = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    n = 2;
    while (!done && n < 40) begin step(); n++; end
    chk("ign.lat", n, 8);
    chk("ign.q", {24'd0, q}, {24'd0, ABORT_Q});
    chk("ign.r", {24'd0, r}, {24'd0, ABORT_R});
    step();

    // Reset in the middle of CALC aborts at once.
    a = 8'd200; b = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    #3 rst_n = 1'b0;
    #1;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.done", {31'd0, done}, 32'd0);
    chk("abort.q", {24'd0, q}, 32'd0);
    chk("abort.r", {24'd0, r}, 32'd0);
    chk("abort.dbz", {31'd0, dbz}, 32'd0);
    chk("abort.state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort.no_done", {31'd0, saw_done}, 32'd0);

    // First request after reset release.
    do_op("post_rst", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
